// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep: drives every WIDTH-bit vector to two functions and compares their outputs.
// Optional EQUIV_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module equiv_sweep_ctrl #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             f_ref,
    input  logic             f_dut,
    output logic [WIDTH-1:0] vec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   fail_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    RELOAD = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] LAST   = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [WIDTH:0]   fc_q, fc_d;
    logic             ffv_q, ffv_d;
    logic [WIDTH-1:0] ffvec_q, ffvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             mismatch;
    logic             sweep_end;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        fc_d      = fc_q;
        ffv_d     = ffv_q;
        ffvec_d   = ffvec_q;
        mismatch  = (f_ref != f_dut);
`ifdef EQUIV_STOP_ON_FAIL_EN
        sweep_end = mismatch || (vec_q == LAST);
`else
        sweep_end = (vec_q == LAST);
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    cnt_d   = RELOAD;
                    vec_d   = '0;
                    fc_d    = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) state_d = S_SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    fc_d = fc_q + 1'b1;
                    if (!ffv_q) begin
                        ffv_d   = 1'b1;
                        ffvec_d = vec_q;
                    end
                end
                // The last vector ends the sweep, so the increment never wraps.
                if (sweep_end) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = RELOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (fc_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            fc_q    <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            fc_q    <= fc_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_out          = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fc_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Bench for equiv_sweep_ctrl: per-run expectations queued at start, compared when done rises.
module tb_equiv_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic start;
    bit   sel;
    int   fmode;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic       st1, st2, fr1, fd1, fr2, fd2;
    logic [2:0] vec1, vec2, ffvec1, ffvec2;
    logic [3:0] fc1, fc2;
    logic       busy1, busy2, done1, done2, pass1, pass2, ffv1, ffv2;

    function automatic logic fref(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

    function automatic logic mm(input int mode, input logic [2:0] v);
        case (mode)
            1: return v == 3'd5;
            2: return 1'b1;
            3: return v == 3'd7;
            4: return v == 3'd1;
            default: return 1'b0;
        endcase
    endfunction

    assign st1 = start && !sel;
    assign st2 = start && sel;
    assign fr1 = fref(vec1);
    assign fd1 = fr1 ^ mm(fmode, vec1);
    assign fr2 = fref(vec2);
    assign fd2 = fr2 ^ mm(fmode, vec2);

    equiv_sweep_ctrl #(.WIDTH(3), .SETTLE(1)) u_dut (
        .clk(clk), .rst(rst), .start(st1), .f_ref(fr1), .f_dut(fd1),
        .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

    equiv_sweep_ctrl #(.WIDTH(3), .SETTLE(3)) u_dut_s3 (
        .clk(clk), .rst(rst), .start(st2), .f_ref(fr2), .f_dut(fd2),
        .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fc2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2));

    wire [2:0] vec_m   = sel ? vec2 : vec1;
    wire [2:0] ffvec_m = sel ? ffvec2 : ffvec1;
    wire [3:0] fc_m    = sel ? fc2 : fc1;
    wire       busy_m  = sel ? busy2 : busy1;
    wire       done_m  = sel ? done2 : done1;
    wire       pass_m  = sel ? pass2 : pass1;
    wire       ffv_m   = sel ? ffv2 : ffv1;

    typedef struct {
        int cyc;
        int fc;
        int ffv;
        int ffvec;
        int pass;
        int vec;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input bit s, input int mode, input bit repulse);
        exp_t e;
        int   st;
        int   n;
        st = s ? 3 : 1;
        e.fc = 0; e.ffv = 0; e.ffvec = 0; e.vec = 0;
        for (int v = 0; v < 8; v++) begin
            e.vec = v;
            if (mm(mode, 3'(v))) begin
                e.fc++;
                if (e.ffv == 0) begin
                    e.ffv   = 1;
                    e.ffvec = v;
                end
`ifdef EQUIV_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        e.cyc  = (e.vec + 1) * (st + 1);
        e.pass = (e.fc == 0) ? 1 : 0;
        sb_q.push_back(e);

        @(negedge clk);
        sel   = s;
        fmode = mode;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_busy", busy_m, 1);
        check("start_vec", vec_m, 0);
        check("start_fc_cleared", fc_m, 0);
        n = 0;
        while (!done_m && n < 300) begin
            @(posedge clk);
            n++;
            #1 start = repulse && (n == 3 || n == 9);
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check("done_latency", n, e.cyc);
        check("fail_count", fc_m, e.fc);
        check("first_fail_valid", ffv_m, e.ffv);
        check("first_fail_vec", ffvec_m, e.ffvec);
        check("pass", pass_m, e.pass);
        check("vec_hold", vec_m, e.vec);
        check("busy_low_done", busy_m, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        fmode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vec", vec1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_fc", fc1, 0);
        check("rst_ffv", ffv1, 0);
        check("rst_ffvec", ffvec1, 0);
        @(negedge clk);
        rst = 1'b0;

        run_sweep(1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done1, 1);
        check("vec_held", vec1, 7);

        run_sweep(1'b0, 1, 1'b0);
        run_sweep(1'b0, 2, 1'b0);
        run_sweep(1'b0, 0, 1'b1);

        // Reset in mid-sweep after a mismatch on vector 1 has been counted.
        @(negedge clk);
        sel   = 1'b0;
        fmode = 4;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_fc", fc1, 1);
        check("pre_rst_ffv", ffv1, 1);
        rst = 1'b1;
        #1;
        check("midrst_vec", vec1, 0);
        check("midrst_busy", busy1, 0);
        check("midrst_done", done1, 0);
        check("midrst_pass", pass1, 0);
        check("midrst_fc", fc1, 0);
        check("midrst_ffv", ffv1, 0);
        check("midrst_ffvec", ffvec1, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle_busy", busy1, 0);
        check("post_rst_idle_done", done1, 0);

        run_sweep(1'b0, 0, 1'b0);
        run_sweep(1'b1, 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/equiv_sweep_ctrl.md
# equiv_sweep_ctrl

Sequencer that checks two combinational implementations of the same Boolean function against each other, exhaustively and in hardware. It sweeps an input vector across all 2^WIDTH values and drives that vector to both function instances. After a programmable settle time it samples and compares their outputs, counts mismatches and records the first failing vector. It sits above a pair of minimized/unminimized logic blocks and reports pass/fail through a start/busy/done handshake.

## Interface
- WIDTH, 3: width of the input vector driven to both functions (1..16).
- SETTLE, 1: cycles between driving a vector and sampling outputs (>=1).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- f_ref  in  1  output of the reference (unminimized) function.
- f_dut  in  1  output of the function under check (minimized).
- vec_out  out  WIDTH  input vector driven to both functions.
- busy  out  1  high while a sweep is in progress (SETTLE/SAMPLE).
- done  out  1  high in DONE; results are valid.
- pass  out  1  done && fail_count==0.
- fail_count  out  WIDTH+1  number of mismatching vectors; saturates never (max 2^WIDTH fits).
- first_fail_valid  out  1  at least one mismatch has been captured this run.
- first_fail_vec  out  WIDTH  vector of the first mismatch.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Reset: state=IDLE; vec_out=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_vec=0; settle counter=0.
- IDLE: start=1 -> SETTLE; vec_out=0, fail_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=SETTLE-1.
- SETTLE: counter decrements each cycle; counter==0 -> SAMPLE.
- SAMPLE (one cycle): if f_ref!=f_dut, fail_count+=1 and, if first_fail_valid==0, first_fail_vec=vec_out and first_fail_valid=1.
  - vec_out == 2^WIDTH-1 -> DONE; vec_out holds the last vector.
  - Otherwise vec_out+=1, counter reloads to SETTLE-1, and the state returns to SETTLE.
- DONE: results are held and vec_out holds. start=1 clears the results and restarts exactly as from IDLE.
- start while busy is ignored; no queuing.
- vec_out increment is WIDTH-bit; the wrap from all-ones is never taken because the last vector ends the sweep.
- f_ref and f_dut are compared only in SAMPLE; their values in other states are ignored.
- rst asserted mid-sweep: all outputs immediately return to reset values; a new start is required.

## Timing
- busy = state in {SETTLE, SAMPLE}, done = state==DONE; both are registered state decodes.
- start sampled high at edge k -> busy=1 and vec_out=0 after edge k.
- Each vector occupies SETTLE+1 cycles. Vector n is driven from edge k+n*(SETTLE+1) and compared at edge k+(n+1)*(SETTLE+1).
- done rises after edge k+2^WIDTH*(SETTLE+1); busy falls on the same edge. For WIDTH=3 and SETTLE=1 this is edge k+16.
- fail_count and first_fail_* update on the SAMPLE edge and are final when done=1.

## Configuration
- EQUIV_STOP_ON_FAIL_EN defined: the first mismatch in SAMPLE sends the state directly to DONE. fail_count=1, first_fail_vec = vec_out, and vec_out holds the failing vector. With no mismatch, the timing is identical to the default.
- Not defined: the full sweep always completes and fail_count is the total mismatch count.

## Test plan
- f_dut tied to f_ref, WIDTH=3, SETTLE=1, start pulse -> done exactly 16 cycles later, pass=1, fail_count=0, first_fail_valid=0.
- f_dut = f_ref XOR (vec_out==5) -> fail_count=1, first_fail_vec=5, pass=0. With EQUIV_STOP_ON_FAIL_EN: done after 12 cycles, vec_out=5.
- f_dut = ~f_ref -> fail_count=8, first_fail_vec=0, first_fail_valid=1.
- start re-pulsed at cycles 3 and 9 of a sweep -> no effect; done still at cycle 16. start in DONE -> results cleared, busy=1, a new 16-cycle sweep runs.
- rst asserted at cycle 7 of a sweep with a mismatch already counted -> all outputs zero immediately, state IDLE; a later start gives a clean run.
- SETTLE=3, single mismatch at vector 7 -> done at cycle 32, first_fail_vec=7, vec_out held at 7.
